data_ram_resp: RTL and testbench

- Responder end of the core's data-memory port. It consumes the core's address, write data, write enable, byte-select and chip-enable outputs, and returns read data.
- Contains a byte-addressable, little-endian word RAM and a small MMIO window:
  - a free-running 64-bit cycle counter;
  - a tohost register that signals simulation halt and carries an exit code.
- Reads are combinational, because the core's MEM stage consumes data in the same cycle. Writes and all state updates are synchronous.

---
 rtl/data_ram_resp_if.sv | 20 ++
 rtl/data_ram_resp.sv | 126 ++++++++++++
 tb/tb_data_ram_resp.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/data_ram_resp_if.sv
// Data-memory port between the core (master) and the RAM/MMIO responder (slave).
// Read data comes back combinationally in the same cycle the access is presented.
interface data_ram_resp_if;
  logic        mem_ce_i;
  logic        mem_we_i;
  logic [31:0] mem_addr_i;
  logic [3:0]  mem_sel_i;
  logic [31:0] mem_data_i;
  logic [31:0] mem_data_o;

  modport master (
    output mem_ce_i, mem_we_i, mem_addr_i, mem_sel_i, mem_data_i,
    input  mem_data_o
  );

  modport slave (
    input  mem_ce_i, mem_we_i, mem_addr_i, mem_sel_i, mem_data_i,
    output mem_data_o
  );
endinterface

// File: rtl/data_ram_resp.sv
// Data-memory responder: byte-lane word RAM plus an MMIO window holding a
// free-running 64-bit cycle counter (coherent lo/hi read) and a tohost halt register.
module data_ram_resp #(
  parameter int          DEPTH_WORDS = 16384,
  parameter int          ADDR_W      = 14,
  parameter logic [31:0] MMIO_BASE   = 32'hFFFF0000
) (
  input  logic              clk,
  input  logic              rst,
  data_ram_resp_if.slave    bus,
  output logic              halt_o,
  output logic [30:0]       exit_code_o,
  output logic              bus_err_o
);

  localparam logic [31:0] RAM_BYTES = 32'(DEPTH_WORDS * 4);

  logic [31:0]       mem_q [DEPTH_WORDS];

  logic [63:0]       cnt_q, cnt_d;
  logic [31:0]       shadow_hi_q, shadow_hi_d;
  logic [31:0]       tohost_q, tohost_d;
  logic              halt_q, halt_d;
  logic [30:0]       exit_code_q, exit_code_d;
  logic              bus_err_q, bus_err_d;

  logic              is_ram, is_mmio, is_hole;
  logic              rd_en, wr_en;
  logic [1:0]        mmio_off;
  logic [ADDR_W-1:0] word_idx;
  logic [31:0]       tohost_merged;
  logic              unused_addr_bits;

  assign is_ram   = bus.mem_addr_i < RAM_BYTES;
  assign is_mmio  = bus.mem_addr_i[31:4] == MMIO_BASE[31:4];
  assign is_hole  = !is_ram && !is_mmio;
  assign rd_en    = bus.mem_ce_i && !bus.mem_we_i;
  assign wr_en    = bus.mem_ce_i && bus.mem_we_i;
  assign mmio_off = bus.mem_addr_i[3:2];
  assign word_idx = bus.mem_addr_i[ADDR_W+1:2];

  // Byte offset is meaningless here: the core expresses lane choice through mem_sel_i.
  assign unused_addr_bits = ^bus.mem_addr_i[1:0];

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_merge
      assign tohost_merged[8*gi +: 8] = bus.mem_sel_i[gi] ? bus.mem_data_i[8*gi +: 8]
                                                          : tohost_q[8*gi +: 8];
    end
  endgenerate

  always_comb begin
    bus.mem_data_o = 32'h0;
    if (rd_en && is_ram) begin
      bus.mem_data_o = mem_q[word_idx];
    end else if (rd_en && is_mmio) begin
      case (mmio_off)
        2'd0:    bus.mem_data_o = cnt_q[31:0];
        2'd1:    bus.mem_data_o = shadow_hi_q;
        2'd2:    bus.mem_data_o = tohost_q;
        default: bus.mem_data_o = 32'h0;
      endcase
    end
  end

  always_comb begin
    cnt_d       = cnt_q + 64'd1;
    shadow_hi_d = shadow_hi_q;
    tohost_d    = tohost_q;
    halt_d      = halt_q;
    exit_code_d = exit_code_q;
    bus_err_d   = bus_err_q;

    // Latch hi from the very counter value whose lo half is being returned now.
    if (rd_en && is_mmio && mmio_off == 2'd0) begin
      shadow_hi_d = cnt_q[63:32];
    end

    if (wr_en && is_mmio && mmio_off == 2'd2) begin
      tohost_d = tohost_merged;
      if (tohost_merged[0] && !halt_q) begin
        halt_d      = 1'b1;
        exit_code_d = tohost_merged[31:1];
      end
    end

    if (bus.mem_ce_i && is_hole) begin
      bus_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q       <= 64'h0;
      shadow_hi_q <= 32'h0;
      tohost_q    <= 32'h0;
      halt_q      <= 1'b0;
      exit_code_q <= 31'h0;
      bus_err_q   <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      shadow_hi_q <= shadow_hi_d;
      tohost_q    <= tohost_d;
      halt_q      <= halt_d;
      exit_code_q <= exit_code_d;
      bus_err_q   <= bus_err_d;
    end
  end

  // RAM has no reset so memory contents stay independent of control-state reset.
  always_ff @(posedge clk) begin
    if (wr_en && is_ram) begin
      for (int i = 0; i < 4; i++) begin
        if (bus.mem_sel_i[i]) begin
          mem_q[word_idx][8*i +: 8] <= bus.mem_data_i[8*i +: 8];
        end
      end
    end
  end

  assign halt_o      = halt_q;
  assign exit_code_o = exit_code_q;
  assign bus_err_o   = bus_err_q;

endmodule

// File: tb/tb_data_ram_resp.sv
// Self-checking bench for data_ram_resp: read results checked via an expected-value
// scoreboard, flag outputs checked against constants after each relevant edge.
module tb_data_ram_resp;

  localparam logic [31:0] MMIO_LO = 32'hFFFF0000;
  localparam logic [31:0] MMIO_HI = 32'hFFFF0004;
  localparam logic [31:0] TOHOST  = 32'hFFFF0008;

  logic        clk;
  logic        rst;
  logic        halt;
  logic [30:0] exit_code;
  logic        bus_err;

  data_ram_resp_if bus ();

  data_ram_resp dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus.slave),
    .halt_o      (halt),
    .exit_code_o (exit_code),
    .bus_err_o   (bus_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } sb_entry_t;

  sb_entry_t sb_q[$];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  task automatic idle();
    bus.mem_ce_i   = 1'b0;
    bus.mem_we_i   = 1'b0;
    bus.mem_addr_i = 32'h0;
    bus.mem_sel_i  = 4'h0;
    bus.mem_data_i = 32'h0;
  endtask

  // Pops the oldest expectation and compares it with the combinational read data.
  task automatic sample_resp();
    sb_entry_t e;
    if (sb_q.size() == 0) begin
      check("sb_underflow", 64'd1, 64'd0);
    end else begin
      e = sb_q.pop_front();
      check(e.tag, {32'h0, bus.mem_data_o}, {32'h0, e.exp});
    end
  endtask

  task automatic rd(input logic [31:0] addr, input logic ce, input logic [31:0] exp,
                    input string tag);
    sb_entry_t e;
    @(negedge clk);
    bus.mem_ce_i   = ce;
    bus.mem_we_i   = 1'b0;
    bus.mem_addr_i = addr;
    bus.mem_sel_i  = 4'hF;
    e.tag = tag;
    e.exp = exp;
    sb_q.push_back(e);
    #2;
    sample_resp();
  endtask

  // Presents a write and returns #1 after the edge that commits it.
  task automatic wr(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] sel);
    @(negedge clk);
    bus.mem_ce_i   = 1'b1;
    bus.mem_we_i   = 1'b1;
    bus.mem_addr_i = addr;
    bus.mem_sel_i  = sel;
    bus.mem_data_i = data;
    @(posedge clk);
    #1;
  endtask

  initial begin
    idle();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_halt", {63'h0, halt}, 64'd0);
    check("rst_exit", {33'h0, exit_code}, 64'd0);
    check("rst_buserr", {63'h0, bus_err}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(posedge clk);
    rd(MMIO_LO, 1'b1, 32'd5, "cnt_after_rst");
    rd(TOHOST, 1'b1, 32'd0, "tohost_rst");

    wr(32'h100, 32'h11223344, 4'hF);
    check("rdata_during_write", {32'h0, bus.mem_data_o}, 64'd0);
    rd(32'h100, 1'b1, 32'h11223344, "ram_word");
    rd(32'h100, 1'b0, 32'h0, "ram_ce0");

    wr(32'h104, 32'hAABBCCDD, 4'hF);
    wr(32'h104, 32'h00EE0000, 4'b0100);
    rd(32'h104, 1'b1, 32'hAAEECCDD, "ram_lane2");
    wr(32'h104, 32'h12345678, 4'b0000);
    rd(32'h104, 1'b1, 32'hAAEECCDD, "ram_sel0");
    wr(32'h104, 32'h000000FF, 4'b0001);
    rd(32'h107, 1'b1, 32'hAAEECCFF, "ram_lane0_ofs3");
    wr(32'h0000FFFC, 32'hCAFEF00D, 4'hF);
    rd(32'h0000FFFC, 1'b1, 32'hCAFEF00D, "ram_top_word");

    @(posedge clk);
    #1;
    force dut.cnt_q = 64'h00000001_FFFFFFFF;
    rd(MMIO_LO, 1'b1, 32'hFFFFFFFF, "cnt_lo_snap");
    @(posedge clk);
    #1;
    release dut.cnt_q;
    rd(MMIO_HI, 1'b1, 32'h00000001, "cnt_hi_snap");

    wr(TOHOST, 32'h0000002A, 4'hF);
    check("halt_bit0_clear", {63'h0, halt}, 64'd0);
    rd(TOHOST, 1'b1, 32'h0000002A, "tohost_2a");
    wr(TOHOST, 32'h0000002B, 4'b0001);
    check("halt_set", {63'h0, halt}, 64'd1);
    check("exit_code_21", {33'h0, exit_code}, 64'd21);
    wr(TOHOST, 32'h00000005, 4'hF);
    check("exit_code_frozen", {33'h0, exit_code}, 64'd21);
    rd(TOHOST, 1'b1, 32'h00000005, "tohost_after_halt");
    check("buserr_clean", {63'h0, bus_err}, 64'd0);

    rd(32'h80000000, 1'b1, 32'h0, "hole_read");
    @(posedge clk);
    #1;
    check("buserr_set", {63'h0, bus_err}, 64'd1);
    @(negedge clk);
    idle();
    repeat (2) @(posedge clk);
    #1;
    check("buserr_sticky", {63'h0, bus_err}, 64'd1);
    wr(32'h80000100, 32'hDEADBEEF, 4'hF);
    wr(32'h00010100, 32'hDEADBEEF, 4'hF);
    rd(32'h100, 1'b1, 32'h11223344, "hole_write_dropped");
    rd(32'hFFFF000C, 1'b1, 32'h0, "mmio_c_zero");

    @(negedge clk);
    rst            = 1'b1;
    bus.mem_ce_i   = 1'b1;
    bus.mem_we_i   = 1'b1;
    bus.mem_addr_i = TOHOST;
    bus.mem_sel_i  = 4'hF;
    bus.mem_data_i = 32'h00000007;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst2_halt", {63'h0, halt}, 64'd0);
    check("rst2_exit", {33'h0, exit_code}, 64'd0);
    check("rst2_buserr", {63'h0, bus_err}, 64'd0);
    rd(MMIO_LO, 1'b1, 32'd0, "rst2_cnt");
    rd(TOHOST, 1'b1, 32'd0, "rst2_tohost");
    rd(32'h100, 1'b1, 32'h11223344, "rst2_ram_kept");

    @(negedge clk);
    idle();
    if (sb_q.size() != 0) check("sb_leftover", 64'(sb_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
